// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath cells:
// FSM state encoding, default operand width and the full-adder result type.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic s;
    logic c;
  } fa_t;

  // One-bit full-adder evaluation: sum is the odd parity of the inputs,
  // carry is their majority.
  function automatic fa_t fa_eval(input logic a, input logic b, input logic cin);
    fa_t r;
    r.s = a ^ b ^ cin;
    r.c = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational one-bit full adder slice, companion to the half_subtractor cell.
module full_adder
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  fa_t res_s;

  // evaluate the slice
  always_comb begin
    res_s = fa_eval(a, b, cin);
    sum   = res_s.s;
    cout  = res_s.c;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are accepted over valid/ready, added
// LSB-first one bit per clock through a single full-adder slice with a
// registered carry, and the result is held on a valid/ready output.
// Optional build macro SERIAL_ADDER_SUB_MODE_EN adds a 'sub' input that turns
// the operation into a - b with the carry output reporting the borrow.
module serial_adder
  import arith_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_sr_r;
  logic [WIDTH-1:0]   b_sr_r;
  logic [WIDTH-1:0]   sum_r;
  logic               c_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               accept_s;
  logic               last_s;
  logic               fa_sum_s;
  logic               fa_cout_s;
  logic               load_sub_s;
  logic               run_sub_s;

  assign accept_s = in_valid & in_ready;
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_MODE_EN
  logic sub_r;

  // remember the operation select for the duration of the serial pass
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_r <= 1'b0;
    end else if (accept_s) begin
      sub_r <= sub;
    end else begin
      sub_r <= sub_r;
    end
  end

  assign load_sub_s = sub;
  assign run_sub_s  = sub_r;
`else
  assign load_sub_s = 1'b0;
  assign run_sub_s  = 1'b0;
`endif

  full_adder u_fa (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .cin  (c_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode; DONE never accepts so operations cannot overlap
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Moore output decode straight from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // operand capture, serial add/shift and result holding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      sum_r   <= '0;
      c_r     <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sr_r <= a;
            // subtraction is a + ~b + 1: invert b and preset the carry
            b_sr_r <= load_sub_s ? ~b : b;
            c_r    <= load_sub_s;
            cnt_r  <= '0;
          end else begin
            a_sr_r <= a_sr_r;
            b_sr_r <= b_sr_r;
            c_r    <= c_r;
            cnt_r  <= cnt_r;
          end
        end
        RUN: begin
          a_sr_r <= a_sr_r >> 1;
          b_sr_r <= b_sr_r >> 1;
          sum_r  <= {fa_sum_s, sum_r[WIDTH-1:1]};
          c_r    <= fa_cout_s;
          if (last_s) begin
            // counter returns to zero so it never exceeds WIDTH-1
            cnt_r   <= '0;
            carry_r <= run_sub_s ? ~fa_cout_s : fa_cout_s;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            carry_r <= carry_r;
          end
        end
        default: begin
          a_sr_r  <= a_sr_r;
          b_sr_r  <= b_sr_r;
          sum_r   <= sum_r;
          c_r     <= c_r;
          carry_r <= carry_r;
          cnt_r   <= cnt_r;
        end
      endcase
    end
  end

  assign sum   = sum_r;
  assign carry = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands
// compared against plain integer arithmetic. Cycle indices count clock
// periods; the period in which an operand handshake is presented is T.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  sum;
  logic        carry;
  logic        busy;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = 16'd0;
  logic [15:0] b16 = 16'd0;
  logic        out_valid16;
  logic [15:0] sum16;
  logic        carry16;
  logic        busy16;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_MODE_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
`ifdef SERIAL_ADDER_SUB_MODE_EN
    .sub       (1'b0),
`endif
    .out_valid (out_valid16),
    .out_ready (1'b1),
    .sum       (sum16),
    .carry     (carry16),
    .busy      (busy16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation; hold = cycles out_ready stays low once out_valid is up.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                     input int hold, input string tag);
    logic [8:0] full;
    logic [7:0] exp_sum;
    logic       exp_c;
    int         t0;
    bit         seen;
    if (sv) begin
      exp_sum = av - bv;
      exp_c   = (av < bv);
    end else begin
      full    = {1'b0, av} + {1'b0, bv};
      exp_sum = full[7:0];
      exp_c   = full[8];
    end
    @(negedge clk);
    chk({tag, ".idle_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    sub       = sv;
    out_ready = (hold == 0);
    t0        = cyc;
    @(posedge clk);
    #1;
    // scramble inputs and keep requesting: none of this may affect the result
    a   = 8'($urandom);
    b   = 8'($urandom);
    sub = 1'($urandom);
    @(negedge clk);
    chk({tag, ".run_busy"}, busy, 1);
    chk({tag, ".run_ready"}, in_ready, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1;
      else @(negedge clk);
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, cyc - t0, 9);
    chk({tag, ".sum"}, sum, exp_sum);
    chk({tag, ".carry"}, carry, exp_c);
    chk({tag, ".done_ready"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".bp_valid"}, out_valid, 1);
      chk({tag, ".bp_sum"}, sum, exp_sum);
      chk({tag, ".bp_carry"}, carry, exp_c);
      chk({tag, ".bp_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".after_valid"}, out_valid, 0);
    chk({tag, ".after_ready"}, in_ready, 1);
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input string tag);
    logic [16:0] full;
    int          t0;
    bit          seen;
    full = {1'b0, av} + {1'b0, bv};
    @(negedge clk);
    in_valid16 = 1'b1;
    a16        = av;
    b16        = bv;
    t0         = cyc;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    a16        = 16'($urandom);
    b16        = 16'($urandom);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid16) seen = 1;
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, cyc - t0, 17);
    chk({tag, ".sum"}, sum16, full[15:0]);
    chk({tag, ".carry"}, carry16, full[16]);
    @(negedge clk);
    chk({tag, ".after_valid"}, out_valid16, 0);
  endtask

  initial begin
    // reset held low with a live request on the input
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.sum", sum, 0);
      chk("rst.carry", carry, 0);
      chk("rst.busy", busy, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("post_rst.no_capture", busy, 0);
    chk("post_rst.ready", in_ready, 1);

    op8(8'd23, 8'd42, 1'b0, 0, "add_23_42");
    op8(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    op8(8'h80, 8'h80, 1'b0, 0, "add_80_80");
    op8(8'h5A, 8'h33, 1'b0, 5, "backpressure");
    op8(8'd17, 8'd200, 1'b0, 0, "after_bp");

    // reset in the middle of a serial pass
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'd100;
    b        = 8'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun.busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun.in_ready", in_ready, 1);
    chk("midrun.out_valid", out_valid, 0);
    chk("midrun.sum", sum, 0);
    chk("midrun.carry", carry, 0);
    chk("midrun.busy0", busy, 0);
    rst_n = 1'b1;
    op8(8'd3, 8'd5, 1'b0, 0, "fresh_3_5");

`ifdef SERIAL_ADDER_SUB_MODE_EN
    op8(8'd10, 8'd3, 1'b1, 0, "sub_10_3");
    op8(8'd3, 8'd10, 1'b1, 0, "sub_3_10");
    op8(8'd77, 8'd77, 1'b1, 1, "sub_equal");
`endif

    for (int k = 0; k < 20; k++) begin
      logic sv;
`ifdef SERIAL_ADDER_SUB_MODE_EN
      sv = 1'($urandom);
`else
      sv = 1'b0;
`endif
      op8(8'($urandom), 8'($urandom), sv, int'($urandom_range(0, 2)), "random");
    end

    op16(16'hFFFF, 16'h0001, "w16_ffff_1");
    op16(16'h1234, 16'hABCD, "w16_mixed");
    op16(16'($urandom), 16'($urandom), "w16_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
